// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode codes, FSM states,
// the flag bundle and opcode classification.
package alu_mc_pkg;

  localparam int unsigned ALUOp_ADD  = 0;
  localparam int unsigned ALUOp_SUB  = 1;
  localparam int unsigned ALUOp_SRA  = 2;
  localparam int unsigned ALUOp_AND  = 3;
  localparam int unsigned ALUOp_OR   = 4;
  localparam int unsigned ALUOp_XOR  = 5;
  localparam int unsigned ALUOp_SLL  = 6;
  localparam int unsigned ALUOp_SRL  = 7;
  localparam int unsigned ALUOp_SLT  = 8;
  localparam int unsigned ALUOp_SLTU = 9;
  localparam int unsigned ALUOp_MULU = 10;
  localparam int unsigned ALUOp_DIVU = 11;
  localparam int unsigned ALUOp_REMU = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } flags_t;

  function automatic logic is_iter_op(input int unsigned code);
    return (code == ALUOp_MULU) || (code == ALUOp_DIVU) || (code == ALUOp_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide/remainder,
// one iteration per cycle; sh_q is the multiplier or the dividend/quotient.
module alu_mc_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             rem_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  import alu_mc_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic             div_q;
  logic             rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] opd_d;
  logic [WIDTH:0]   trial_s;

  // One iteration: divide shifts the next dividend bit into the remainder,
  // multiply adds the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    sh_d    = sh_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    trial_s = {(WIDTH+1){1'b0}};
    if (div_q) begin
      trial_s = {acc_q, sh_q[WIDTH-1]} - {1'b0, opd_q};
      sh_d    = {sh_q[WIDTH-2:0], ~trial_s[WIDTH]};
      if (trial_s[WIDTH]) begin
        acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
      end else begin
        acc_d = trial_s[WIDTH-1:0];
      end
    end else begin
      acc_d = acc_q + (sh_q[0] ? opd_q : {WIDTH{1'b0}});
      sh_d  = {1'b0, sh_q[WIDTH-1:1]};
      opd_d = {opd_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done_o   = busy_q && (cnt_q == {CW{1'b0}});
  assign result_o = (div_q && !rem_q) ? sh_d : acc_d;

  // Operand load on start, then iterate until the counter expires.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      sh_q   <= {WIDTH{1'b0}};
      acc_q  <= {WIDTH{1'b0}};
      opd_q  <= {WIDTH{1'b0}};
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      rem_q  <= rem_i;
      cnt_q  <= CW'(WIDTH - 1);
      sh_q   <= div_i ? a_i : b_i;
      opd_q  <= div_i ? b_i : a_i;
      acc_q  <= {WIDTH{1'b0}};
    end else if (busy_q) begin
      busy_q <= (cnt_q != {CW{1'b0}});
      cnt_q  <= cnt_q - CW'(1);
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      opd_q  <= opd_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake FSM, single-cycle datapath and
// registered result/flags; mul/div/rem are delegated to alu_mc_muldiv.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);
  import alu_mc_pkg::*;

  localparam int SW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] c_q;
  flags_t           flags_q;

  logic [SW-1:0]    shamt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic             alu_ovf_s;
  logic             alu_ill_s;
  flags_t           alu_flags_d;
  flags_t           iter_flags_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             is_iter_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_res_s;

  assign shamt_s = B[SW-1:0];
  assign sum_s   = {1'b0, A} + {1'b0, B};
  assign dif_s   = {1'b0, A} - {1'b0, B};

  assign is_iter_s  = is_iter_op(32'(op));
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Single-cycle datapath; bit WIDTH of sum/diff is carry-out/borrow.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_ill_s   = 1'b0;
    case (op)
      OPW'(ALUOp_ADD): begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OPW'(ALUOp_SUB): begin
        alu_res_s   = dif_s[WIDTH-1:0];
        alu_carry_s = dif_s[WIDTH];
        alu_ovf_s   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_s[WIDTH-1] != A[WIDTH-1]);
      end
      OPW'(ALUOp_SRA):  alu_res_s = $unsigned($signed(A) >>> shamt_s);
      OPW'(ALUOp_AND):  alu_res_s = A & B;
      OPW'(ALUOp_OR):   alu_res_s = A | B;
      OPW'(ALUOp_XOR):  alu_res_s = A ^ B;
      OPW'(ALUOp_SLL):  alu_res_s = A << shamt_s;
      OPW'(ALUOp_SRL):  alu_res_s = A >> shamt_s;
      OPW'(ALUOp_SLT):  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OPW'(ALUOp_SLTU): alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OPW'(ALUOp_MULU), OPW'(ALUOp_DIVU), OPW'(ALUOp_REMU): alu_res_s = {WIDTH{1'b0}};
      default:          alu_ill_s = 1'b1;
    endcase
  end

  always_comb begin
    alu_flags_d.zero    = (alu_res_s == {WIDTH{1'b0}});
    alu_flags_d.neg     = alu_res_s[WIDTH-1];
    alu_flags_d.carry   = alu_carry_s;
    alu_flags_d.ovf     = alu_ovf_s;
    alu_flags_d.illegal = alu_ill_s;
    iter_flags_d.zero    = (iter_res_s == {WIDTH{1'b0}});
    iter_flags_d.neg     = iter_res_s[WIDTH-1];
    iter_flags_d.carry   = 1'b0;
    iter_flags_d.ovf     = 1'b0;
    iter_flags_d.illegal = 1'b0;
  end

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (accept_s && is_iter_s),
    .div_i    (op != OPW'(ALUOp_MULU)),
    .rem_i    (op == OPW'(ALUOp_REMU)),
    .a_i      (A),
    .b_i      (B),
    .done_o   (iter_done_s),
    .result_o (iter_res_s)
  );

  // Handshake FSM; C and flags only change when a new result is written.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      c_q     <= {WIDTH{1'b0}};
      flags_q <= flags_t'(5'b00000);
    end else if (accept_s) begin
      if (is_iter_s) begin
        state_q <= ST_BUSY;
      end else begin
        state_q <= ST_DONE;
        c_q     <= alu_res_s;
        flags_q <= alu_flags_d;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_BUSY: begin
          if (iter_done_s) begin
            state_q <= ST_DONE;
            c_q     <= iter_res_s;
            flags_q <= iter_flags_d;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == ST_DONE);
  assign C         = c_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign illegal   = flags_q.illegal;

endmodule
